gpio_cmd_regfile: RTL and testbench
===================================

# gpio_cmd_regfile

Parametrised command register file between the soft microcontroller's GPIO (gpi0/gpo0) and the convolution video pipeline. It decodes toggle-qualified commands from the micro, drives kernel select, load and start pulses, and tracks frame progress with an explicit state machine. It prefetches processed pixel words from frame memory into a read FIFO so that GET_FRAME returns data without memory stalls. It also exposes a status word with sticky error flags.

## Interface
Parameters:
- NB_INST, 32: GPIO word width.
- NB_CMD, 7: command field width, bits [NB_INST-2:NB_INST-1-NB_CMD].
- NB_DATA, 24: payload width, bits [NB_DATA-1:0]; NB_CMD+NB_DATA+1 == NB_INST.
- N_KERNELS, 4: number of selectable kernels; NB_KSEL = $clog2(N_KERNELS).
- FRAME_WORDS, 1024: memory words per processed frame.
- FIFO_DEPTH, 8: read FIFO depth, power of two, ≥2.

Ports:
- clock, in, 1: sole clock.
- reset, in, 1: asynchronous, active-low reset.
- i_cmd_from_micro, in, NB_INST: gpi0; bit NB_INST-1 is the command toggle.
- o_data_to_micro, out, NB_INST: gpo0.
- o_kernel_sel, out, NB_KSEL: active kernel.
- o_load, out, 1: one-cycle strobe, payload valid on o_pixels_from_micro.
- o_pixels_from_micro, out, NB_DATA: payload, combinational from gpi0.
- o_start_conv, out, 1: one-cycle strobe.
- i_frame_ready, in, 1: level, processed frame available.
- o_mem_rd_req, out, 1: one-cycle read request to frame memory.
- o_mem_rd_addr, out, $clog2(FRAME_WORDS): read address.
- i_mem_rd_valid, in, 1: read data valid, any latency ≥1, in order.
- i_mem_rd_data, in, NB_INST: read data.

## Operation
- Command accepted on any toggle of bit NB_INST-1, rising or falling, compared against a registered copy. A new command needs one GPIO write, not two.
- Codes:
  - KERNEL_SEL=0: o_kernel_sel <= payload[NB_KSEL-1:0]. Values ≥ N_KERNELS set ERR_CMD and leave the select unchanged.
  - LOAD_FRAME=1: o_load pulse. Legal in IDLE and LOADING; goes to LOADING.
  - END_FRAME=2: o_load and o_start_conv pulse. Goes to CONVOLVING.
  - IS_FRAME_READY=3: o_data_to_micro <= zero-extended i_frame_ready.
  - GET_FRAME=4: pops the FIFO into o_data_to_micro. If the FIFO is empty, returns 0 and sets ERR_UNDER.
  - GET_STATUS=5: o_data_to_micro <= status, then the sticky bits clear.
  - SOFT_RESET=6: same effect as reset, except the toggle history is kept.
  - Any other code sets ERR_CMD.
  - A legal code issued in the wrong state is ignored and sets ERR_CMD.
- States: IDLE → LOADING → CONVOLVING → READOUT → IDLE.
  - CONVOLVING→READOUT when i_frame_ready=1; the address counter is cleared on entry.
  - READOUT→IDLE after the FRAME_WORDS-th GET_FRAME pop.
- Prefetch runs in READOUT only.
  - o_mem_rd_req=1 when requested < FRAME_WORDS and fifo_count + outstanding < FIFO_DEPTH.
  - The address increments per request.
  - i_mem_rd_valid pushes into the FIFO. Overflow is impossible by credit accounting.
- Status word:
  - [1:0] state (IDLE=0, LOADING=1, CONVOLVING=2, READOUT=3).
  - [2] i_frame_ready.
  - [3] ERR_UNDER.
  - [4] ERR_CMD.
  - [8 +: $clog2(FIFO_DEPTH)+1] fifo_count.
  - All other bits 0.

## Timing
- Reset values:
  - All outputs 0, including o_kernel_sel, o_data_to_micro, o_mem_rd_addr and strobes.
  - State IDLE, FIFO empty, sticky bits 0.
  - Toggle copy equals 0.
- Latency: a gpi0 change at cycle t is detected at t+1. o_kernel_sel, o_data_to_micro and strobes update at t+1.
- Strobes last exactly one cycle. A held gpi0 with no toggle produces no further action.
- A GET_FRAME pop at the cycle of an i_mem_rd_valid push is legal; the count is unchanged. A pop on an empty FIFO with a simultaneous push returns 0 and stores the word.
- If GET_STATUS and a new error occur in the same cycle, the new error remains set afterwards.
- Asynchronous reset mid-READOUT discards the FIFO and outstanding credits. Late i_mem_rd_valid after reset is dropped while state ≠ READOUT.
- SOFT_RESET takes effect at t+1, equivalent to reset from t+2.

## Structure
- Package gpio_cmd_pkg: command codes, state encoding, status bit positions.
- Sub-module cmd_rd_fifo: synchronous FIFO with count output, push, pop, data in and data out. All other logic lives in gpio_cmd_regfile.

## Test plan
- Reset, then toggle with KERNEL_SEL payload 2 → o_kernel_sel=2 at t+1. Re-write the same word with no toggle → no change. Payload 5 with N_KERNELS=4 → select stays 2, status[4]=1.
- Three LOAD_FRAME commands with alternating toggle, then END_FRAME → three o_load pulses, then o_load and o_start_conv in the same cycle; status[1:0]=2.
- FRAME_WORDS=16, FIFO_DEPTH=4, memory latency 3, i_frame_ready raised → at most 4 outstanding plus stored words. Sixteen GET_FRAME commands return words 0..15 in order. State returns to IDLE.
- GET_FRAME in READOUT with an empty FIFO → returns 0, status[3]=1. A following GET_STATUS shows bit 3 set; the next GET_STATUS shows it clear.
- Unknown code 0x7F → status[4]=1 with no other effect. GET_FRAME in IDLE → ignored, status[4]=1.
- Assert reset for one cycle mid-READOUT with valid data pending → all outputs 0, state IDLE. A late i_mem_rd_valid does not change fifo_count.

Source files
------------

// File: rtl/gpio_cmd_pkg.sv
// Shared command codes, state encoding and status-word layout for the GPIO
// command register file.
package gpio_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOADING    = 2'd1,
        ST_CONVOLVING = 2'd2,
        ST_READOUT    = 2'd3
    } state_e;

    localparam int CMD_KERNEL_SEL     = 0;
    localparam int CMD_LOAD_FRAME     = 1;
    localparam int CMD_END_FRAME      = 2;
    localparam int CMD_IS_FRAME_READY = 3;
    localparam int CMD_GET_FRAME      = 4;
    localparam int CMD_GET_STATUS     = 5;
    localparam int CMD_SOFT_RESET     = 6;

    localparam int STAT_STATE_LSB   = 0;
    localparam int STAT_FRAME_READY = 2;
    localparam int STAT_ERR_UNDER   = 3;
    localparam int STAT_ERR_CMD     = 4;
    localparam int STAT_FIFO_LSB    = 8;

endpackage

// File: rtl/cmd_rd_fifo.sv
// Small synchronous FIFO holding prefetched frame words; head word is visible
// combinationally on rd_data, and count reports occupancy.
module cmd_rd_fifo
    import gpio_cmd_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: the storage array is not reset; pointers and count define which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/gpio_cmd_regfile.sv
// Command register file between the micro's GPIO and the convolution pipeline:
// toggle-qualified command decode, frame FSM, and credit-limited readout prefetch.
module gpio_cmd_regfile
    import gpio_cmd_pkg::*;
#(
    parameter  int NB_INST     = 32,
    parameter  int NB_CMD      = 7,
    parameter  int NB_DATA     = 24,
    parameter  int N_KERNELS   = 4,
    parameter  int FRAME_WORDS = 1024,
    parameter  int FIFO_DEPTH  = 8,
    localparam int NB_KSEL     = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1,
    localparam int NB_ADDR     = $clog2(FRAME_WORDS),
    localparam int NB_CNT      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NB_INST-1:0] i_cmd_from_micro,
    output logic [NB_INST-1:0] o_data_to_micro,
    output logic [NB_KSEL-1:0] o_kernel_sel,
    output logic               o_load,
    output logic [NB_DATA-1:0] o_pixels_from_micro,
    output logic               o_start_conv,
    input  logic               i_frame_ready,
    output logic               o_mem_rd_req,
    output logic [NB_ADDR-1:0] o_mem_rd_addr,
    input  logic               i_mem_rd_valid,
    input  logic [NB_INST-1:0] i_mem_rd_data
);

    logic               cmd_toggle, toggle_q, cmd_new;
    logic [NB_CMD-1:0]  cmd_code;
    logic [NB_DATA-1:0] payload;

    state_e             state_q, state_d;
    logic [NB_KSEL-1:0] ksel_q, ksel_d;
    logic [NB_INST-1:0] data_q, data_d;
    logic               load_q, load_d, start_q, start_d;
    logic               err_under_q, err_under_d, err_cmd_q, err_cmd_d;
    logic [NB_ADDR:0]   req_cnt_q, req_cnt_d, pop_cnt_q, pop_cnt_d;
    logic [NB_CNT-1:0]  outstanding_q, outstanding_d;

    logic [NB_INST-1:0] status;
    logic [NB_INST-1:0] fifo_rd_data;
    logic [NB_CNT-1:0]  fifo_count;
    logic [NB_CNT:0]    credit_used;
    logic               fifo_push, fifo_pop, fifo_clear, mem_req, soft_reset;

    assign cmd_toggle = i_cmd_from_micro[NB_INST-1];
    assign cmd_code   = i_cmd_from_micro[NB_INST-2 -: NB_CMD];
    assign payload    = i_cmd_from_micro[NB_DATA-1:0];
    assign cmd_new    = cmd_toggle ^ toggle_q;

    // Words already stored plus words in flight may never exceed the FIFO depth.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign mem_req     = (state_q == ST_READOUT)
                      && (req_cnt_q < (NB_ADDR+1)'(FRAME_WORDS))
                      && (credit_used < (NB_CNT+1)'(FIFO_DEPTH));
    assign fifo_push   = (state_q == ST_READOUT) && i_mem_rd_valid && (outstanding_q != '0);

    always_comb begin
        status = '0;
        status[STAT_STATE_LSB +: 2]      = state_q;
        status[STAT_FRAME_READY]         = i_frame_ready;
        status[STAT_ERR_UNDER]           = err_under_q;
        status[STAT_ERR_CMD]             = err_cmd_q;
        status[STAT_FIFO_LSB +: NB_CNT]  = fifo_count;
    end

    always_comb begin
        // NOTE: every signal gets its default first, so no path can infer a latch.
        state_d     = state_q;
        ksel_d      = ksel_q;
        data_d      = data_q;
        load_d      = 1'b0;
        start_d     = 1'b0;
        err_under_d = err_under_q;
        err_cmd_d   = err_cmd_q;
        fifo_pop    = 1'b0;
        soft_reset  = 1'b0;

        if (state_q == ST_CONVOLVING && i_frame_ready) state_d = ST_READOUT;

        if (cmd_new) begin
            case (int'(cmd_code))
                CMD_KERNEL_SEL: begin
                    if (payload < NB_DATA'(N_KERNELS)) ksel_d = payload[NB_KSEL-1:0];
                    else err_cmd_d = 1'b1;
                end
                CMD_LOAD_FRAME: begin
                    if (state_q == ST_IDLE || state_q == ST_LOADING) begin
                        load_d  = 1'b1;
                        state_d = ST_LOADING;
                    end else err_cmd_d = 1'b1;
                end
                CMD_END_FRAME: begin
                    if (state_q == ST_LOADING) begin
                        load_d  = 1'b1;
                        start_d = 1'b1;
                        state_d = ST_CONVOLVING;
                    end else err_cmd_d = 1'b1;
                end
                CMD_IS_FRAME_READY: data_d = NB_INST'(i_frame_ready);
                CMD_GET_FRAME: begin
                    if (state_q != ST_READOUT) begin
                        err_cmd_d = 1'b1;
                    end else if (fifo_count != '0) begin
                        data_d   = fifo_rd_data;
                        fifo_pop = 1'b1;
                        if (pop_cnt_q == (NB_ADDR+1)'(FRAME_WORDS - 1)) state_d = ST_IDLE;
                    end else begin
                        data_d      = '0;
                        err_under_d = 1'b1;
                    end
                end
                CMD_GET_STATUS: begin
                    data_d      = status;
                    err_under_d = 1'b0;
                    err_cmd_d   = 1'b0;
                end
                CMD_SOFT_RESET: soft_reset = 1'b1;
                default:        err_cmd_d  = 1'b1;
            endcase
        end

        if (soft_reset) begin
            state_d     = ST_IDLE;
            ksel_d      = '0;
            data_d      = '0;
            err_under_d = 1'b0;
            err_cmd_d   = 1'b0;
        end

        // Leaving READOUT by any route drops stored words and in-flight credits.
        fifo_clear = (state_d != ST_READOUT);
        if (fifo_clear) begin
            req_cnt_d     = '0;
            pop_cnt_d     = '0;
            outstanding_d = '0;
        end else begin
            req_cnt_d     = req_cnt_q + (NB_ADDR+1)'(mem_req);
            pop_cnt_d     = pop_cnt_q + (NB_ADDR+1)'(fifo_pop);
            outstanding_d = outstanding_q + NB_CNT'(mem_req) - NB_CNT'(fifo_push);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            toggle_q      <= 1'b0;
            state_q       <= ST_IDLE;
            ksel_q        <= '0;
            data_q        <= '0;
            load_q        <= 1'b0;
            start_q       <= 1'b0;
            err_under_q   <= 1'b0;
            err_cmd_q     <= 1'b0;
            req_cnt_q     <= '0;
            pop_cnt_q     <= '0;
            outstanding_q <= '0;
        end else begin
            toggle_q      <= cmd_toggle;
            state_q       <= state_d;
            ksel_q        <= ksel_d;
            data_q        <= data_d;
            load_q        <= load_d;
            start_q       <= start_d;
            err_under_q   <= err_under_d;
            err_cmd_q     <= err_cmd_d;
            req_cnt_q     <= req_cnt_d;
            pop_cnt_q     <= pop_cnt_d;
            outstanding_q <= outstanding_d;
        end
    end

    cmd_rd_fifo #(
        .WIDTH (NB_INST),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clock   (clock),
        .reset   (reset),
        .clear   (fifo_clear),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (i_mem_rd_data),
        .rd_data (fifo_rd_data),
        .count   (fifo_count)
    );

    assign o_data_to_micro     = data_q;
    assign o_kernel_sel        = ksel_q;
    assign o_load              = load_q;
    assign o_start_conv        = start_q;
    assign o_pixels_from_micro = payload;
    assign o_mem_rd_req        = mem_req;
    assign o_mem_rd_addr       = req_cnt_q[NB_ADDR-1:0];

endmodule

// File: tb/tb_gpio_cmd_regfile.sv
// Randomised bench for gpio_cmd_regfile: a command-level reference model and a
// fixed-latency frame memory responder.
module tb_gpio_cmd_regfile;

    localparam int NB_INST = 32;
    localparam int NB_CMD  = 7;
    localparam int NB_DATA = 24;
    localparam int NK      = 4;
    localparam int FW      = 16;
    localparam int DEPTH   = 4;
    localparam int LAT     = 3;

    localparam int C_KSEL = 0, C_LOAD = 1, C_END = 2, C_RDY = 3;
    localparam int C_GET  = 4, C_STAT = 5, C_SRST = 6;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [NB_INST-1:0] i_cmd_from_micro = '0;
    logic [NB_INST-1:0] o_data_to_micro;
    logic [1:0]         o_kernel_sel;
    logic               o_load;
    logic [NB_DATA-1:0] o_pixels_from_micro;
    logic               o_start_conv;
    logic               i_frame_ready = 1'b0;
    logic               o_mem_rd_req;
    logic [3:0]         o_mem_rd_addr;
    logic               i_mem_rd_valid = 1'b0;
    logic [NB_INST-1:0] i_mem_rd_data = '0;

    always #5 clock = ~clock;

    gpio_cmd_regfile #(
        .NB_INST     (NB_INST),
        .NB_CMD      (NB_CMD),
        .NB_DATA     (NB_DATA),
        .N_KERNELS   (NK),
        .FRAME_WORDS (FW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .i_cmd_from_micro    (i_cmd_from_micro),
        .o_data_to_micro     (o_data_to_micro),
        .o_kernel_sel        (o_kernel_sel),
        .o_load              (o_load),
        .o_pixels_from_micro (o_pixels_from_micro),
        .o_start_conv        (o_start_conv),
        .i_frame_ready       (i_frame_ready),
        .o_mem_rd_req        (o_mem_rd_req),
        .o_mem_rd_addr       (o_mem_rd_addr),
        .i_mem_rd_valid      (i_mem_rd_valid),
        .i_mem_rd_data       (i_mem_rd_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Frame memory image and responder bookkeeping.
    logic [31:0] mem_img [FW];
    typedef struct { int addr; int due; } rd_t;
    rd_t pend[$];
    rd_t rd;
    int  cyc = 0;
    int  exp_addr = 0;
    int  reqs = 0;
    int  pops = 0;
    bit  credit_bad = 1'b0;

    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            i_mem_rd_valid = 1'b0;
            i_mem_rd_data  = '0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                rd = pend.pop_front();
                i_mem_rd_valid = 1'b1;
                i_mem_rd_data  = mem_img[rd.addr];
            end
            if (o_mem_rd_req) begin
                check("rd_addr", 32'(o_mem_rd_addr), 32'(exp_addr));
                pend.push_back('{int'(o_mem_rd_addr), cyc + LAT});
                exp_addr++;
                reqs++;
                if (reqs - pops > DEPTH) credit_bad = 1'b1;
            end
        end
    end

    // Reference model at command granularity.
    bit          tog = 1'b0;
    int          m_state = 0;
    int          m_ksel = 0;
    int          m_popped = 0;
    bit          m_eu = 1'b0;
    bit          m_ec = 1'b0;
    bit          m_settled = 1'b0;
    logic [31:0] m_data = '0;

    function automatic logic [31:0] model_status();
        int cnt;
        cnt = 0;
        if (m_state == 3 && m_settled) cnt = (FW - m_popped < DEPTH) ? FW - m_popped : DEPTH;
        return 32'(m_state) | (32'(i_frame_ready) << 2) | (32'(m_eu) << 3)
             | (32'(m_ec) << 4) | (32'(cnt) << 8);
    endfunction

    function automatic void model_reset();
        m_state   = 0;
        m_ksel    = 0;
        m_data    = '0;
        m_eu      = 1'b0;
        m_ec      = 1'b0;
        m_popped  = 0;
        m_settled = 1'b0;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
        if (m_state == 3 && n >= 10) m_settled = 1'b1;
    endtask

    task automatic send_cmd(input int code, input int payload, input string tag);
        logic exp_load;
        logic exp_start;
        exp_load  = 1'b0;
        exp_start = 1'b0;
        case (code)
            C_KSEL: if (payload < NK) m_ksel = payload; else m_ec = 1'b1;
            C_LOAD: if (m_state <= 1) begin exp_load = 1'b1; m_state = 1; end else m_ec = 1'b1;
            C_END:  if (m_state == 1) begin exp_load = 1'b1; exp_start = 1'b1; m_state = 2; end
                    else m_ec = 1'b1;
            C_RDY:  m_data = 32'(i_frame_ready);
            C_GET: begin
                if (m_state != 3) m_ec = 1'b1;
                else if (m_settled) begin
                    m_data = mem_img[m_popped];
                    m_popped++;
                    pops++;
                    m_settled = 1'b0;
                    if (m_popped == FW) m_state = 0;
                end else begin
                    m_data = '0;
                    m_eu   = 1'b1;
                end
            end
            C_STAT: begin m_data = model_status(); m_eu = 1'b0; m_ec = 1'b0; end
            C_SRST: model_reset();
            default: m_ec = 1'b1;
        endcase

        tog = ~tog;
        i_cmd_from_micro = {tog, NB_CMD'(code), NB_DATA'(payload)};
        #1;
        check({tag, "_pix"}, 32'(o_pixels_from_micro), 32'(payload) & 32'h00FF_FFFF);
        @(negedge clock);
        check({tag, "_ksel"},  32'(o_kernel_sel), 32'(m_ksel));
        check({tag, "_data"},  o_data_to_micro, m_data);
        check({tag, "_load"},  32'(o_load), 32'(exp_load));
        check({tag, "_start"}, 32'(o_start_conv), 32'(exp_start));
        @(negedge clock);
        check({tag, "_load_end"},  32'(o_load), 32'd0);
        check({tag, "_start_end"}, 32'(o_start_conv), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"},  o_data_to_micro, 32'd0);
        check({tag, "_ksel"},  32'(o_kernel_sel), 32'd0);
        check({tag, "_load"},  32'(o_load), 32'd0);
        check({tag, "_start"}, 32'(o_start_conv), 32'd0);
        check({tag, "_req"},   32'(o_mem_rd_req), 32'd0);
        check({tag, "_addr"},  32'(o_mem_rd_addr), 32'd0);
    endtask

    task automatic enter_readout();
        i_frame_ready = 1'b1;
        exp_addr = 0;
        reqs = 0;
        pops = 0;
        @(negedge clock);
        m_state   = 3;
        m_popped  = 0;
        m_settled = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < FW; i++) mem_img[i] = $urandom;
        repeat (2) @(negedge clock);
        check_zero("reset");
        reset = 1'b1;
        idle(2);

        send_cmd(C_KSEL, 2, "ksel2");
        // Payload changes without a toggle: not a command.
        i_cmd_from_micro[NB_DATA-1:0] = 24'd1;
        idle(3);
        check("hold_ksel", 32'(o_kernel_sel), 32'(m_ksel));
        check("hold_load", 32'(o_load), 32'd0);
        check("hold_data", o_data_to_micro, m_data);
        send_cmd(C_KSEL, 5, "ksel5");
        send_cmd(C_STAT, 0, "stat_ec");
        send_cmd(C_STAT, 0, "stat_ec_clr");
        send_cmd(127, 0, "bad_code");
        send_cmd(C_STAT, 0, "stat_bad");
        send_cmd(C_GET, 0, "get_idle");
        send_cmd(C_STAT, 0, "stat_get_idle");

        repeat (6) begin
            i_frame_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) send_cmd(C_KSEL, $urandom_range(0, 7), "rnd_ksel");
            else send_cmd(C_RDY, $urandom_range(0, 255), "rnd_rdy");
        end
        i_frame_ready = 1'b0;
        send_cmd(C_STAT, 0, "stat_rnd");

        repeat (3) send_cmd(C_LOAD, $urandom_range(0, 24'hFF_FFFF), "load");
        send_cmd(C_END, $urandom_range(0, 24'hFF_FFFF), "end");
        send_cmd(C_RDY, 0, "rdy_conv");
        send_cmd(C_STAT, 0, "stat_conv");
        send_cmd(C_LOAD, 0, "load_conv");

        enter_readout();
        send_cmd(C_GET, 0, "get_empty");
        idle(12);
        send_cmd(C_STAT, 0, "stat_under");
        send_cmd(C_STAT, 0, "stat_under_clr");
        for (int k = 0; k < FW; k++) begin
            send_cmd(C_GET, 0, "get_frame");
            idle($urandom_range(10, 14));
        end
        check("credit_limit", 32'(credit_bad), 32'd0);
        send_cmd(C_STAT, 0, "stat_done");
        i_frame_ready = 1'b0;

        send_cmd(C_KSEL, 3, "ksel3");
        send_cmd(C_LOAD, 0, "load_sr");
        i_frame_ready = 1'b1;
        send_cmd(C_RDY, 0, "rdy_sr");
        i_frame_ready = 1'b0;
        send_cmd(C_SRST, 0, "soft_rst");
        send_cmd(C_STAT, 0, "stat_sr");
        send_cmd(C_LOAD, 0, "load_b");
        send_cmd(C_KSEL, 1, "ksel1");
        send_cmd(C_END, 0, "end_b");
        enter_readout();
        idle(2);

        reset = 1'b0;
        i_cmd_from_micro = '0;
        tog = 1'b0;
        i_frame_ready = 1'b0;
        #1;
        check_zero("mid_rst");
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        idle(LAT + 4);
        check("late_req", 32'(o_mem_rd_req), 32'd0);
        send_cmd(C_STAT, 0, "stat_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
